// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
// Optional perf counters are enabled with MULTICYCLE_PERF_CNT_EN.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } mc_state_e;

  localparam logic PCSEL_PC4 = 1'b0;
  localparam logic PCSEL_TGT = 1'b1;

  localparam int unsigned MC_MEM_TIMEOUT_DEF = 16;
  localparam int unsigned MC_PERF_W          = 32;

  // Per-cycle strobes and requests toward the datapath and memories
  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic ir_we;
    logic pc_we;
    logic pc_sel;
    logic rf_we;
    logic retire;
    logic fault;
  } mc_ctrl_t;

  function automatic int unsigned mc_timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait counter: clears on state change, counts ready=0 cycles,
// flags the cycle that would be the MEM_TIMEOUT-th wait (never when MEM_TIMEOUT=0).
module multicycle_ctrl_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MC_MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = mc_timer_width(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle brings the count to MEM_TIMEOUT
  assign expired_o = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-ALU RV32I datapath.
// Define MULTICYCLE_PERF_CNT_EN to add cycle_cnt/instret_cnt outputs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MC_MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic        dec_regwen,
  input  logic        dec_memrw,
  input  logic        dec_memtoreg,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic        retire,
  output logic        fault,
  output logic [2:0]  state_o
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  mc_state_e state_q, state_d;
  mc_ctrl_t  ctl;
  logic      wait_c;
  logic      expired_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    wait_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctl.imem_req = 1'b1;
        if (imem_ready) begin
          ctl.ir_we = 1'b1;
          state_d   = ST_DECODE;
        end else begin
          wait_c = 1'b1;
          if (expired_c) state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = dec_valid ? ST_EXEC : ST_FAULT;
      end
      ST_EXEC: begin
        if (dec_branch) begin
          ctl.pc_we  = 1'b1;
          ctl.pc_sel = br_taken ? PCSEL_TGT : PCSEL_PC4;
          ctl.retire = 1'b1;
          state_d    = ST_FETCH;
        end else if (dec_memrw || dec_memtoreg) begin
          state_d = ST_MEM;
        end else if (dec_jump || dec_regwen) begin
          state_d = ST_WB;
        end else begin
          ctl.pc_we  = 1'b1;
          ctl.pc_sel = PCSEL_PC4;
          ctl.retire = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_MEM: begin
        ctl.dmem_req = 1'b1;
        ctl.dmem_we  = dec_memrw;
        if (dmem_ready) begin
          if (dec_memrw) begin
            ctl.pc_we  = 1'b1;
            ctl.pc_sel = PCSEL_PC4;
            ctl.retire = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          wait_c = 1'b1;
          if (expired_c) state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        ctl.rf_we  = 1'b1;
        ctl.pc_we  = 1'b1;
        ctl.pc_sel = dec_jump ? PCSEL_TGT : PCSEL_PC4;
        ctl.retire = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FAULT: begin
        ctl.fault = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Any state change clears the counter, so FETCH/MEM always start from zero
  multicycle_ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_d != state_q),
    .en_i      (wait_c),
    .expired_o (expired_c)
  );

  // Reset forces every output low immediately, aborting any pending request
  always_comb begin
    {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, fault} =
      rst ? mc_ctrl_t'('0) : ctl;
    state_o = rst ? 3'(ST_FETCH) : 3'(state_q);
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [MC_PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [MC_PERF_W-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = (state_q != ST_FAULT) ? cycle_cnt_q + MC_PERF_W'(1) : cycle_cnt_q;
    instret_cnt_d = ctl.retire ? instret_cnt_q + MC_PERF_W'(1) : instret_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl (MEM_TIMEOUT=4), plus
// hand-written timeout, invalid-opcode and reset-abort sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dec_valid, dec_regwen, dec_memrw, dec_memtoreg, dec_branch, dec_jump, br_taken;
  logic imem_ready, dmem_ready;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, fault;
  logic [2:0] state_o;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_regwen   (dec_regwen),
    .dec_memrw    (dec_memrw),
    .dec_memtoreg (dec_memtoreg),
    .dec_branch   (dec_branch),
    .dec_jump     (dec_jump),
    .br_taken     (br_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .retire       (retire),
    .fault        (fault),
    .state_o      (state_o)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  // {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, fault, state}
  logic [11:0] outv;
  assign outv = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, fault, state_o};

  // Decoder classes: {valid, regwen, memrw, memtoreg, branch, jump, br_taken}
  localparam logic [6:0] ADD  = 7'b1100000;
  localparam logic [6:0] BEQT = 7'b1000101;
  localparam logic [6:0] BEQN = 7'b1000100;
  localparam logic [6:0] LW   = 7'b1101000;
  localparam logic [6:0] SW   = 7'b1010000;
  localparam logic [6:0] JAL  = 7'b1100010;
  localparam logic [6:0] NOP  = 7'b1000000;
  localparam logic [6:0] INV  = 7'b0100000;

  localparam logic [11:0] E_FW  = 12'b1000_0000_0_000;
  localparam logic [11:0] E_FR  = 12'b1001_0000_0_000;
  localparam logic [11:0] E_DEC = 12'b0000_0000_0_001;
  localparam logic [11:0] E_EX  = 12'b0000_0000_0_010;
  localparam logic [11:0] E_WB  = 12'b0000_1011_0_100;
  localparam logic [11:0] E_WBJ = 12'b0000_1111_0_100;
  localparam logic [11:0] E_BRT = 12'b0000_1101_0_010;
  localparam logic [11:0] E_BRN = 12'b0000_1001_0_010;
  localparam logic [11:0] E_LD  = 12'b0100_0000_0_011;
  localparam logic [11:0] E_STD = 12'b0110_1001_0_011;
  localparam logic [11:0] E_STW = 12'b0110_0000_0_011;
  localparam logic [11:0] E_FLT = 12'b0000_0000_1_101;

  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic [8:0] v);
    {dec_valid, dec_regwen, dec_memrw, dec_memtoreg, dec_branch, dec_jump, br_taken,
     imem_ready, dmem_ready} = v;
  endtask

  // Called at posedge+1: drive, compare at negedge, advance to next posedge+1
  task automatic step(input string name, input logic [8:0] in, input logic [11:0] exp);
    set_in(in);
    @(negedge clk);
    chk(name, 32'(outv), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(9'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outs", 32'(outv), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_in(9'd0);

    vq.push_back('{"add_fw",   {ADD,  2'b00}, E_FW});
    vq.push_back('{"add_fr",   {ADD,  2'b10}, E_FR});
    vq.push_back('{"add_dec",  {ADD,  2'b00}, E_DEC});
    vq.push_back('{"add_ex",   {ADD,  2'b00}, E_EX});
    vq.push_back('{"add_wb",   {ADD,  2'b00}, E_WB});
    vq.push_back('{"beqt_fr",  {BEQT, 2'b10}, E_FR});
    vq.push_back('{"beqt_dec", {BEQT, 2'b00}, E_DEC});
    vq.push_back('{"beqt_ex",  {BEQT, 2'b00}, E_BRT});
    vq.push_back('{"beqn_fr",  {BEQN, 2'b10}, E_FR});
    vq.push_back('{"beqn_dec", {BEQN, 2'b00}, E_DEC});
    vq.push_back('{"beqn_ex",  {BEQN, 2'b00}, E_BRN});
    vq.push_back('{"lw_fr",    {LW,   2'b10}, E_FR});
    vq.push_back('{"lw_dec",   {LW,   2'b00}, E_DEC});
    vq.push_back('{"lw_ex",    {LW,   2'b00}, E_EX});
    vq.push_back('{"lw_mw1",   {LW,   2'b00}, E_LD});
    vq.push_back('{"lw_mw2",   {LW,   2'b00}, E_LD});
    vq.push_back('{"lw_mw3",   {LW,   2'b00}, E_LD});
    vq.push_back('{"lw_mrdy",  {LW,   2'b01}, E_LD});
    vq.push_back('{"lw_wb",    {LW,   2'b00}, E_WB});
    vq.push_back('{"sw_fr",    {SW,   2'b10}, E_FR});
    vq.push_back('{"sw_dec",   {SW,   2'b00}, E_DEC});
    vq.push_back('{"sw_ex",    {SW,   2'b00}, E_EX});
    vq.push_back('{"sw_mrdy",  {SW,   2'b01}, E_STD});
    vq.push_back('{"jal_fr",   {JAL,  2'b10}, E_FR});
    vq.push_back('{"jal_dec",  {JAL,  2'b00}, E_DEC});
    vq.push_back('{"jal_ex",   {JAL,  2'b00}, E_EX});
    vq.push_back('{"jal_wb",   {JAL,  2'b00}, E_WBJ});
    vq.push_back('{"nop_fr",   {NOP,  2'b10}, E_FR});
    vq.push_back('{"nop_dec",  {NOP,  2'b00}, E_DEC});
    vq.push_back('{"nop_ex",   {NOP,  2'b00}, E_BRN});
    vq.push_back('{"late_fw1", {ADD,  2'b00}, E_FW});
    vq.push_back('{"late_fw2", {ADD,  2'b00}, E_FW});
    vq.push_back('{"late_fw3", {ADD,  2'b00}, E_FW});
    vq.push_back('{"late_fr4", {ADD,  2'b10}, E_FR});
    vq.push_back('{"late_dec", {ADD,  2'b00}, E_DEC});
    vq.push_back('{"late_ex",  {ADD,  2'b00}, E_EX});
    vq.push_back('{"late_wb",  {ADD,  2'b00}, E_WB});

    do_reset();
    foreach (vq[i]) step(vq[i].name, vq[i].in, vq[i].exp);

    // Fetch timeout: four wait cycles, then sticky FAULT despite ready
    do_reset();
    for (int i = 0; i < 4; i++) step("fto_wait", {ADD, 2'b00}, E_FW);
    for (int i = 0; i < 3; i++) step("fto_fault", {ADD, 2'b11}, E_FLT);

    // Undecodable opcode
    do_reset();
    step("inv_fr", {INV, 2'b10}, E_FR);
    step("inv_dec", {INV, 2'b00}, E_DEC);
    for (int i = 0; i < 3; i++) step("inv_fault", {ADD, 2'b11}, E_FLT);

    // Data-side timeout on a store
    do_reset();
    step("dto_fr", {SW, 2'b10}, E_FR);
    step("dto_dec", {SW, 2'b00}, E_DEC);
    step("dto_ex", {SW, 2'b00}, E_EX);
    for (int i = 0; i < 4; i++) step("dto_wait", {SW, 2'b00}, E_STW);
    step("dto_fault", {SW, 2'b01}, E_FLT);

    // Reset mid-MEM: request drops immediately, load never retires
    do_reset();
    step("rmem_fr", {LW, 2'b10}, E_FR);
    step("rmem_dec", {LW, 2'b00}, E_DEC);
    step("rmem_ex", {LW, 2'b00}, E_EX);
    step("rmem_mw", {LW, 2'b00}, E_LD);
    set_in({LW, 2'b00});
    #2;
    chk("rmem_req_pre", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmem_drop", 32'(outv), 32'd0);
    set_in({LW, 2'b01});
    @(posedge clk);
    #1;
    chk("rmem_hold", 32'(outv), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("rmem_noret", {LW, 2'b01}, E_FW);

`ifdef MULTICYCLE_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step("perf_fw", {ADD, 2'b00}, E_FW);
      step("perf_fr", {ADD, 2'b10}, E_FR);
      step("perf_dec", {ADD, 2'b00}, E_DEC);
      step("perf_ex", {ADD, 2'b00}, E_EX);
      step("perf_wb", {ADD, 2'b00}, E_WB);
    end
    chk("perf_instret", instret_cnt, 32'd10);
    chk("perf_cycle", cycle_cnt, 32'd50);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
